// File: rtl/troca_contexto_rr.sv
// troca_contexto_rr: round-robin preemptive context-switch controller.
// Ports: clock/reset, retire info (pc_in, instr_valid), process control
// (proc_create/create_id/create_pc, proc_start/start_id, io_req, proc_end),
// table read (rd_id -> rd_pc), swap outputs (swap, swap_pc, cause),
// status (current_proc, next_proc, active, in_kernel).
// Macro TROCA_CTX_QUANTUM_PER_PROC_EN adds q_wr/q_id/q_val per-slot quanta.
module troca_contexto_rr #(
  parameter int NPROC    = 8,
  parameter int PC_W     = 32,
  parameter int QW       = 8,
  parameter int QUANTUM  = 16,
  parameter int SCHED_PC = 1,
  parameter int IO_PC    = 92
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [PC_W-1:0]          pc_in,
  input  logic                     instr_valid,
  input  logic                     proc_create,
  input  logic [$clog2(NPROC)-1:0] create_id,
  input  logic [PC_W-1:0]          create_pc,
  input  logic                     proc_start,
  input  logic [$clog2(NPROC)-1:0] start_id,
`ifdef TROCA_CTX_QUANTUM_PER_PROC_EN
  input  logic                     q_wr,
  input  logic [$clog2(NPROC)-1:0] q_id,
  input  logic [QW-1:0]            q_val,
`endif
  input  logic                     io_req,
  input  logic                     proc_end,
  input  logic [$clog2(NPROC)-1:0] rd_id,
  output logic [PC_W-1:0]          rd_pc,
  output logic                     swap,
  output logic [PC_W-1:0]          swap_pc,
  output logic [1:0]               cause,
  output logic [$clog2(NPROC)-1:0] current_proc,
  output logic [$clog2(NPROC)-1:0] next_proc,
  output logic [NPROC-1:0]         active,
  output logic                     in_kernel
);

  localparam int IDW = $clog2(NPROC);

  typedef enum logic [1:0] {
    KERNEL = 2'd0,
    RUN    = 2'd1,
    SWAP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    cur_q, cur_d;
  logic [QW-1:0]     cnt_q, cnt_d;
  logic [NPROC-1:0]  act_q, act_d;
  logic              swap_q, swap_d;
  logic [PC_W-1:0]   swap_pc_q, swap_pc_d;
  logic [1:0]        cause_q, cause_d;
  logic [PC_W-1:0]   rd_pc_q, rd_pc_d;
  logic [PC_W-1:0]   tbl_q [NPROC];
  logic [PC_W-1:0]   tbl_d [NPROC];
  logic              save;
  logic              expire;
  logic [QW-1:0]     qsel;
  logic [QW-1:0]     qload;

`ifdef TROCA_CTX_QUANTUM_PER_PROC_EN
  logic [QW-1:0]     qtab_q [NPROC];
  logic [QW-1:0]     qtab_d [NPROC];

  always_comb begin
    qtab_d = qtab_q;
    if (q_wr) qtab_d[q_id] = q_val;
    qsel = qtab_q[start_id];
  end
`else
  always_comb begin
    qsel = QW'(QUANTUM);
  end
`endif

  // A zero quantum would never expire; run at least one instruction.
  assign qload  = (qsel == '0) ? QW'(1) : qsel;
  assign expire = instr_valid && (cnt_q == QW'(1));

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    act_d     = act_q;
    swap_d    = 1'b0;
    swap_pc_d = swap_pc_q;
    cause_d   = cause_q;
    save      = 1'b0;
    unique case (state_q)
      KERNEL: begin
        if (proc_start && act_q[start_id]) begin
          cur_d   = start_id;
          cnt_d   = qload;
          state_d = RUN;
        end
      end
      RUN: begin
        if (instr_valid && cnt_q != '0) cnt_d = cnt_q - QW'(1);
        if (proc_end) begin
          act_d[cur_q] = 1'b0;
          swap_pc_d    = PC_W'(SCHED_PC);
          cause_d      = 2'd3;
          swap_d       = 1'b1;
          state_d      = SWAP;
        end else if (io_req) begin
          save      = 1'b1;
          swap_pc_d = PC_W'(IO_PC);
          cause_d   = 2'd2;
          swap_d    = 1'b1;
          state_d   = SWAP;
        end else if (expire) begin
          save      = 1'b1;
          swap_pc_d = PC_W'(SCHED_PC);
          cause_d   = 2'd1;
          swap_d    = 1'b1;
          state_d   = SWAP;
        end
      end
      SWAP: state_d = KERNEL;
      default: state_d = KERNEL;
    endcase
    if (proc_create) act_d[create_id] = 1'b1;
  end

  // Save is applied after create so it wins a same-slot collision.
  always_comb begin
    tbl_d = tbl_q;
    if (proc_create) tbl_d[create_id] = create_pc;
    if (save) tbl_d[cur_q] = pc_in + PC_W'(1);
    rd_pc_d = tbl_q[rd_id];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= KERNEL;
      cur_q     <= '0;
      cnt_q     <= '0;
      act_q     <= '0;
      swap_q    <= 1'b0;
      swap_pc_q <= '0;
      cause_q   <= '0;
      rd_pc_q   <= '0;
`ifdef TROCA_CTX_QUANTUM_PER_PROC_EN
      for (int i = 0; i < NPROC; i++) qtab_q[i] <= QW'(QUANTUM);
`endif
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      act_q     <= act_d;
      swap_q    <= swap_d;
      swap_pc_q <= swap_pc_d;
      cause_q   <= cause_d;
      rd_pc_q   <= rd_pc_d;
`ifdef TROCA_CTX_QUANTUM_PER_PROC_EN
      qtab_q    <= qtab_d;
`endif
    end
  end

  // Saved-PC table survives reset.
  always_ff @(posedge clock) begin
    tbl_q <= tbl_d;
  end

  // Descending scan: last hit is the lowest index in each class.
  logic [IDW-1:0] lo_idx, hi_idx;
  logic           lo_ok, hi_ok;

  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    lo_ok  = 1'b0;
    hi_ok  = 1'b0;
    for (int i = NPROC - 1; i >= 0; i--) begin
      if (act_q[i]) begin
        lo_idx = IDW'(i);
        lo_ok  = 1'b1;
        if (i > int'(cur_q)) begin
          hi_idx = IDW'(i);
          hi_ok  = 1'b1;
        end
      end
    end
    next_proc = hi_ok ? hi_idx : (lo_ok ? lo_idx : '0);
  end

  assign rd_pc        = rd_pc_q;
  assign swap         = swap_q;
  assign swap_pc      = swap_pc_q;
  assign cause        = cause_q;
  assign current_proc = cur_q;
  assign active       = act_q;
  assign in_kernel    = (state_q != RUN);

endmodule
